f1_light_sequencer: RTL and testbench

Controller for the start-lights sequence. On a trigger it lights `N_LIGHTS` lamps one per tick. It then waits a random hold time drawn from the 4-bit LFSR, turns all lamps off and pulses `done`. The block sits between the tick prescaler and the lamp outputs, and owns the LFSR enable so the random value depends on when the user pressed trigger.

---
 rtl/f1_pkg.sv | 13 +
 rtl/f1_light_sequencer_hold_counter.sv | 27 ++
 rtl/f1_light_sequencer.sv | 94 +++++++++
 tb/tb_f1_light_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared types and defaults for the start-light sequencer.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } f1_state_t;

    localparam int DEFAULT_N_LIGHTS = 8;
    localparam int DEFAULT_LFSR_W   = 4;

endpackage

// File: rtl/f1_light_sequencer_hold_counter.sv
// Loadable down-counter that times the random hold after the last lamp lights.
module hold_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_one
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign is_one = (count_reg == W'(1));

endmodule

// File: rtl/f1_light_sequencer.sv
// Start-lights controller: fills lamps one per tick, holds for a random
// number of ticks taken from the external LFSR, then blacks out and pulses done.
module f1_light_sequencer
    import f1_pkg::*;
#(
    parameter int N_LIGHTS = DEFAULT_N_LIGHTS,
    parameter int LFSR_W   = DEFAULT_LFSR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                trigger,
    input  logic [LFSR_W-1:0]   lfsr_data,
    output logic                lfsr_en,
    output logic [N_LIGHTS-1:0] lights,
    output logic                busy,
    output logic                done
);

    f1_state_t             state_reg;
    logic [N_LIGHTS-1:0]   lights_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic                  last_fill;
    logic                  hold_load;
    logic                  hold_dec;
    logic [LFSR_W-1:0]     hold_load_val;
    logic                  hold_is_one;

    // The tick that lights the MSB is the one where the lamp below it is already lit.
    assign last_fill     = lights_reg[N_LIGHTS-2];
    assign hold_load     = (state_reg == FILL) && tick && last_fill;
    assign hold_load_val = (lfsr_data == '0) ? LFSR_W'(1) : lfsr_data;
    assign hold_dec      = (state_reg == HOLD) && tick && !hold_is_one;

    hold_counter #(
        .W (LFSR_W)
    ) u_hold_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (hold_load_val),
        .dec      (hold_dec),
        .is_one   (hold_is_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            lights_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        state_reg <= FILL;
                        busy_reg  <= 1'b1;
                    end
                end
                FILL: begin
                    if (tick) begin
                        lights_reg <= {lights_reg[N_LIGHTS-2:0], 1'b1};
                        if (last_fill) begin
                            state_reg <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick && hold_is_one) begin
                        lights_reg <= '0;
                        done_reg   <= 1'b1;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    lights_reg <= '0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    // The LFSR keeps stepping until the hold length is captured, then freezes.
    assign lfsr_en = (state_reg != HOLD);
    assign lights  = lights_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_f1_light_sequencer.sv
// Scoreboard bench: the driver predicts each visible output change from the
// fill/hold rules; a negedge monitor pops and compares whenever outputs change.
module tb_f1_light_sequencer;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic         trigger = 1'b0;
    logic [W-1:0] lfsr_data = '0;
    logic         lfsr_en;
    logic [N-1:0] lights;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    f1_light_sequencer #(
        .N_LIGHTS (N),
        .LFSR_W   (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .trigger   (trigger),
        .lfsr_data (lfsr_data),
        .lfsr_en   (lfsr_en),
        .lights    (lights),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [N-1:0] lights;
        logic         done;
        logic         busy;
        int           tick_no;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           issued = 0;
    int           tick_seen = 0;
    bit           mon_en = 1'b0;
    logic [N+1:0] prev = '0;
    logic [N+1:0] cur;
    logic         exp_en;
    exp_t         e;
    int           seq_no = 0;

    always @(posedge clk) begin
        if (!rst && tick) tick_seen++;
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            cur    = {lights, done, busy};
            exp_en = !(busy && (&lights));
            checks++;
            if (lfsr_en !== exp_en) begin
                errors++;
                $display("FAIL lfsr_en: got %b want %b (lights=%h busy=%b)", lfsr_en, exp_en, lights, busy);
            end
            if (prev[1] && done) begin
                checks++;
                errors++;
                $display("FAIL done_width: done high for more than one cycle");
            end
            if (cur !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got lights=%h done=%b busy=%b with nothing expected",
                             lights, done, busy);
                end else begin
                    e = sb.pop_front();
                    if ({e.lights, e.done, e.busy} !== cur || (e.tick_no >= 0 && e.tick_no != tick_seen)) begin
                        errors++;
                        $display("FAIL output: got lights=%h done=%b busy=%b tick=%0d want lights=%h done=%b busy=%b tick=%0d",
                                 lights, done, busy, tick_seen, e.lights, e.done, e.busy, e.tick_no);
                    end else begin
                        $display("seq %0d: lights=%h done=%b busy=%b tick=%0d ok",
                                 seq_no, lights, done, busy, tick_seen);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] l, input logic d, input logic b, input int t);
        exp_t x;
        x.lights  = l;
        x.done    = d;
        x.busy    = b;
        x.tick_no = t;
        sb.push_back(x);
    endtask

    task automatic chk_reset(input string tag);
        checks += 4;
        if (lights !== '0) begin errors++; $display("FAIL %s lights: got %h want 00", tag, lights); end
        if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", tag, done); end
        if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", tag, busy); end
        if (lfsr_en !== 1'b1) begin errors++; $display("FAIL %s lfsr_en: got %b want 1", tag, lfsr_en); end
    endtask

    // One full sequence. force_v < 0 picks a random LFSR value at capture.
    task automatic run_seq(input bit tick_with_trig, input int force_v,
                           input int gap_min, input int gap_max, input bit abort);
        int           k;
        logic [W-1:0] v;
        logic [N-1:0] lv;
        seq_no++;
        k         = 0;
        trigger   = 1'b1;
        tick      = tick_with_trig;
        if (tick_with_trig) issued++;
        lfsr_data = W'($urandom);
        push('0, 1'b0, 1'b1, -1);
        step();
        for (int n = 1; n <= N + 16; n++) begin
            repeat ($urandom_range(gap_max, gap_min)) begin
                tick      = 1'b0;
                trigger   = ($urandom_range(2, 0) == 0);
                lfsr_data = W'($urandom);
                step();
            end
            tick = 1'b1;
            issued++;
            trigger   = ($urandom_range(2, 0) == 0);
            lfsr_data = W'($urandom);
            if (n < N) begin
                lv = N'((1 << n) - 1);
                push(lv, 1'b0, 1'b1, issued);
            end else if (n == N) begin
                v         = (force_v >= 0) ? W'(force_v) : W'($urandom);
                lfsr_data = v;
                k         = (v == '0) ? 1 : int'(v);
                push({N{1'b1}}, 1'b0, 1'b1, issued);
            end else if (n == N + k) begin
                push('0, 1'b1, 1'b0, issued);
            end
            step();
            if (abort && n == N) begin
                tick    = 1'b0;
                trigger = 1'b0;
                step();
                mon_en = 1'b0;
                #1 rst = 1'b1;
                #1 chk_reset("mid_hold_reset");
                #1 rst = 1'b0;
                sb.delete();
                prev   = '0;
                mon_en = 1'b1;
                repeat (3) step();
                return;
            end
            if (n > N && n == N + k) break;
        end
        tick    = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic post(input bit retrig);
        if (!retrig) begin
            push('0, 1'b0, 1'b0, -1);
            repeat ($urandom_range(5, 1)) begin
                tick = ($urandom_range(1, 0) == 1);
                if (tick) issued++;
                trigger   = 1'b0;
                lfsr_data = W'($urandom);
                step();
            end
            tick = 1'b0;
        end
    endtask

    initial begin
        #2 chk_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        prev   = '0;
        mon_en = 1'b1;
        step();
        step();

        run_seq(1'b0, 5, 3, 3, 1'b0);   post(1'b0);
        run_seq(1'b0, 0, 3, 3, 1'b0);   post(1'b0);
        run_seq(1'b0, 15, 3, 3, 1'b0);  post(1'b0);
        run_seq(1'b1, -1, 3, 3, 1'b0);  post(1'b1);
        run_seq(1'b0, -1, 0, 0, 1'b0);  post(1'b0);
        run_seq(1'b0, -1, 3, 3, 1'b1);
        run_seq(1'b0, 5, 3, 3, 1'b0);   post(1'b0);

        for (int s = 0; s < 20; s++) begin
            int fv;
            case ($urandom_range(3, 0))
                0:       fv = 0;
                1:       fv = 15;
                default: fv = -1;
            endcase
            run_seq(1'($urandom_range(1, 0)), fv, 0, 4, 1'b0);
            post(1'($urandom_range(1, 0)));
        end
        post(1'b0);
        repeat (4) step();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending expectations want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
